// File: rtl/video_timing_gen.sv
// Raster timing generator: sync/blank decode, viewport byte-fetch strobes and
// text-row counters for an NTSC/PAL display, format switch applied per frame.
module video_timing_gen #(
  parameter int H_TOTAL      = 458,
  parameter int HSYNC_COLS   = 28,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312,
  parameter int VSYNC_ROWS   = 8,
  parameter int BLANK_COLS   = 38,
  parameter int PORT_X       = 129,
  parameter int PORT_W       = 256,
  parameter int PORT_Y_NTSC  = 63,
  parameter int PORT_Y_PAL   = 88,
  parameter int PORT_H       = 192,
  parameter int PRELOAD_LEAD = 8,
  parameter int CHAR_ROWS    = 12,
  parameter int BLINK_BIT    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_format,
  input  logic [1:0] i_mode,
  output logic       o_hsn,
  output logic       o_fsn,
  output logic [1:0] o_active,
  output logic       o_preload,
  output logic       o_byte_strobe,
  output logic [5:0] o_byte_idx,
  output logic [7:0] o_line_idx,
  output logic [3:0] o_char_line,
  output logic       o_rowclear,
  output logic       o_frame_start,
  output logic       o_blink
);

  localparam int FETCH_X  = PORT_X - PRELOAD_LEAD;
  localparam int PORT_X_E = PORT_X + PORT_W;

  logic [8:0] r_col;
  logic [8:0] r_row;
  logic       r_fmt;
  logic [1:0] r_mode;
  logic [5:0] r_byteIdx;
  logic [7:0] r_lineIdx;
  logic [7:0] r_frameCnt;
  logic [3:0] r_charLine;

  logic [9:0] w_row;
  logic [9:0] w_nextRow;
  logic [9:0] w_vTot;
  logic [9:0] w_portY;
  logic [9:0] w_portYEnd;
  logic [9:0] w_fetchOff;
  logic       w_lineEnd;
  logic       w_frameEnd;
  logic       w_vpRow;
  logic       w_vpCol;
  logic       w_nextVpRow;
  logic       w_onPitch;
  logic       w_strobe;
  logic [5:0] w_lastIdx;

  // Row comparisons run at 10 bits so port_y + PORT_H never wraps.
  assign w_row       = {1'b0, r_row};
  assign w_vTot      = r_fmt ? 10'(V_TOTAL_PAL) : 10'(V_TOTAL_NTSC);
  assign w_portY     = r_fmt ? 10'(PORT_Y_PAL) : 10'(PORT_Y_NTSC);
  assign w_portYEnd  = w_portY + 10'(PORT_H);
  assign w_lineEnd   = (r_col == 9'(H_TOTAL - 1));
  assign w_frameEnd  = w_lineEnd && (w_row == w_vTot - 10'd1);
  assign w_nextRow   = w_frameEnd ? 10'd0 : w_row + 10'd1;
  assign w_vpRow     = (w_row >= w_portY) && (w_row < w_portYEnd);
  assign w_nextVpRow = (w_nextRow >= w_portY) && (w_nextRow < w_portYEnd);
  assign w_vpCol     = ({1'b0, r_col} >= 10'(PORT_X)) && ({1'b0, r_col} < 10'(PORT_X_E));
  assign w_fetchOff  = {1'b0, r_col} - 10'(FETCH_X);

  always_comb begin
    w_onPitch = (w_fetchOff % 10'(PORT_W / 32)) == 10'd0;
    w_lastIdx = 6'd31;
    case (r_mode)
      2'b01: begin
        w_onPitch = (w_fetchOff % 10'(PORT_W / 16)) == 10'd0;
        w_lastIdx = 6'd15;
      end
      2'b10: begin
        w_onPitch = (w_fetchOff % 10'(PORT_W / 8)) == 10'd0;
        w_lastIdx = 6'd7;
      end
      default: ;
    endcase
  end

  assign w_strobe = w_vpRow && (r_col >= 9'(FETCH_X)) && (w_fetchOff < 10'(PORT_W)) && w_onPitch;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_col      <= 9'd0;
      r_row      <= 9'd0;
      r_fmt      <= 1'b0;
      r_mode     <= 2'b00;
      r_byteIdx  <= 6'd0;
      r_lineIdx  <= 8'd0;
      r_charLine <= 4'd0;
      r_frameCnt <= 8'd0;
    end else begin
      if (r_col == 9'd0) r_mode <= i_mode;
      if (w_lineEnd) begin
        r_col     <= 9'd0;
        r_row     <= w_nextRow[8:0];
        r_byteIdx <= 6'd0;
        if (w_nextRow == w_portY) begin
          r_lineIdx  <= 8'd0;
          r_charLine <= 4'd0;
        end else if (w_nextVpRow) begin
          r_lineIdx  <= r_lineIdx + 8'd1;
          r_charLine <= (r_charLine == 4'(CHAR_ROWS - 1)) ? 4'd0 : r_charLine + 4'd1;
        end
        // Format only takes effect on a frame boundary.
        if (w_frameEnd) begin
          r_fmt      <= i_format;
          r_frameCnt <= r_frameCnt + 8'd1;
        end
      end else begin
        r_col <= r_col + 9'd1;
        if (w_strobe && (r_byteIdx != w_lastIdx)) r_byteIdx <= r_byteIdx + 6'd1;
      end
    end
  end

  assign o_hsn         = (r_col >= 9'(HSYNC_COLS));
  assign o_fsn         = (r_row >= 9'(VSYNC_ROWS));
  assign o_active      = (!o_fsn || (r_col < 9'(BLANK_COLS))) ? 2'b00 :
                         (w_vpRow && w_vpCol) ? 2'b11 : 2'b10;
  assign o_preload     = w_strobe && (w_fetchOff == 10'd0);
  assign o_byte_strobe = w_strobe;
  assign o_byte_idx    = r_byteIdx;
  assign o_line_idx    = r_lineIdx;
  assign o_char_line   = r_charLine;
  assign o_rowclear    = (r_col == 9'd0) && w_vpRow && (w_row != w_portY) && (r_charLine == 4'd0);
  assign o_frame_start = (r_col == 9'd0) && (r_row == 9'd0);
  assign o_blink       = r_frameCnt[BLINK_BIT];

endmodule
